// File: rtl/pixel_event_requester.sv
// pixel_event_requester
//   Pixel-side front end of the pixel-level arbiter. Each pixel latches a
//   one-cycle event into a request, holds it until granted, then stays blind
//   for a refractory period. Group membership is frozen while a group is being
//   served: late events wait in PENDING until the arbiter's group release.
//
// Ports
//   grp_release_clk  block clock
//   reset_i          asynchronous, active-high reset
//   enable_i         level enable from the hierarchy
//   event_i          one-cycle event pulses, one per pixel
//   gnt_i            one-hot grant from the arbiter
//   grp_release_i    arbiter group release (current group fully served)
//   req_o            per-pixel requests (ARMED & enable_i)
//   grp_enable_o     group active and no pixel left ARMED
//   pending_o        some pixel is waiting for the next group
//   drop_cnt_o       saturating count of dropped events
//   gnt_err_o        sticky: grant to a non-ARMED pixel or multi-hot grant

// Per-pixel request FSM.
//   evt/gnt        this pixel's event and grant
//   group_active   block-level group register (decides ARMED vs PENDING)
//   armed          current state is ARMED
//   armed_nxt      next state is ARMED (feeds the group register)
//   pending        current state is PENDING
//   drop           an accepted event hit a busy pixel this cycle
//   gnt_bad        grant arrived while not ARMED
module pixel_event_cell #(
  parameter int REFRACT_CYC = 3
) (
  input  logic grp_release_clk,
  input  logic reset_i,
  input  logic enable,
  input  logic evt,
  input  logic gnt,
  input  logic grp_release,
  input  logic group_active,
  output logic armed,
  output logic armed_nxt,
  output logic pending,
  output logic drop,
  output logic gnt_bad
);

  // Counter must hold REFRACT_CYC; keep at least one bit when it is 0.
  localparam int RW = (REFRACT_CYC > 0) ? $clog2(REFRACT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, PENDING, REFRACT} state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  cnt, cnt_nxt;

  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        // A release in the same cycle opens the new group, so join it.
        if (enable && evt)
          state_nxt = (!group_active || grp_release) ? ARMED : PENDING;
      end
      ARMED: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (gnt) begin
          if (REFRACT_CYC == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = REFRACT;
            cnt_nxt   = RW'(REFRACT_CYC);
          end
        end
      end
      PENDING: begin
        if (!enable)          state_nxt = IDLE;
        else if (grp_release) state_nxt = ARMED;
      end
      REFRACT: begin
        // Hold-off keeps running even while the level is disabled.
        cnt_nxt = cnt - RW'(1);
        if (cnt == RW'(1)) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    armed     = (state == ARMED);
    armed_nxt = (state_nxt == ARMED);
    pending   = (state == PENDING);
    drop      = enable & evt & (state != IDLE);
    gnt_bad   = gnt & (state != ARMED);
  end

endmodule

module pixel_event_requester #(
  parameter int Lvl_ROWS    = 2,
  parameter int Lvl_COLS    = 2,
  parameter int REFRACT_CYC = 3,
  parameter int CNT_W       = 8
) (
  input  logic                               grp_release_clk,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  event_i,
  input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  gnt_i,
  input  logic                               grp_release_i,
  output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  req_o,
  output logic                               grp_enable_o,
  output logic                               pending_o,
  output logic [CNT_W-1:0]                   drop_cnt_o,
  output logic                               gnt_err_o
);

  localparam int N  = Lvl_ROWS * Lvl_COLS;
  localparam int SW = $clog2(N + 1);

  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] armed, armed_nxt, pend, drop, gnt_bad;
  logic                              group_active, group_active_nxt;
  logic [SW-1:0]                     ndrop;
  logic [CNT_W+SW-1:0]               cnt_sum;
  logic [CNT_W-1:0]                  cnt_nxt;
  logic                              multi_hot;

  for (genvar r = 0; r < Lvl_ROWS; r++) begin : g_row
    for (genvar c = 0; c < Lvl_COLS; c++) begin : g_col
      pixel_event_cell #(.REFRACT_CYC(REFRACT_CYC)) u_cell (
        .grp_release_clk (grp_release_clk),
        .reset_i         (reset_i),
        .enable          (enable_i),
        .evt             (event_i[r][c]),
        .gnt             (gnt_i[r][c]),
        .grp_release     (grp_release_i),
        .group_active    (group_active),
        .armed           (armed[r][c]),
        .armed_nxt       (armed_nxt[r][c]),
        .pending         (pend[r][c]),
        .drop            (drop[r][c]),
        .gnt_bad         (gnt_bad[r][c])
      );
    end
  end

  // Release restarts membership from the pixels armed for the new group;
  // otherwise the group only grows until released. Disable tears it down.
  always_comb begin
    if (!enable_i)          group_active_nxt = 1'b0;
    else if (grp_release_i) group_active_nxt = |armed_nxt;
    else                    group_active_nxt = group_active | (|armed_nxt);
  end

  // Several pixels may drop in one cycle; sum in a wider adder, then clamp.
  always_comb begin
    ndrop     = SW'($countones(drop));
    cnt_sum   = {{SW{1'b0}}, drop_cnt_o} + {{CNT_W{1'b0}}, ndrop};
    cnt_nxt   = (cnt_sum > {{SW{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                        : cnt_sum[CNT_W-1:0];
    multi_hot = ($countones(gnt_i) > 1);
  end

  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      group_active <= 1'b0;
      drop_cnt_o   <= '0;
      gnt_err_o    <= 1'b0;
    end else begin
      group_active <= group_active_nxt;
      drop_cnt_o   <= cnt_nxt;
      gnt_err_o    <= gnt_err_o | (|gnt_bad) | multi_hot;
    end
  end

  // Enable masks requests combinationally so the arbiter sees them vanish
  // in the same cycle, before the pixel states are torn down.
  always_comb begin
    req_o        = armed & {N{enable_i}};
    grp_enable_o = group_active & ~(|armed);
    pending_o    = |pend;
  end

endmodule

// File: tb/tb_pixel_event_requester.sv
module tb_pixel_event_requester;
  localparam int R = 2, C = 2, N = 4, RC = 3;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, rel = 1'b0;
  logic [R-1:0][C-1:0] ev = '0, gn = '0;
  logic [R-1:0][C-1:0] req, req_s;
  logic genb, genb_s, pend, pend_s, err, err_s;
  logic [7:0] dcnt;
  logic [1:0] dcnt_s;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pixel_event_requester #(.Lvl_ROWS(R), .Lvl_COLS(C), .REFRACT_CYC(RC), .CNT_W(8)) dut (
    .grp_release_clk(clk), .reset_i(rst), .enable_i(en), .event_i(ev), .gnt_i(gn),
    .grp_release_i(rel), .req_o(req), .grp_enable_o(genb), .pending_o(pend),
    .drop_cnt_o(dcnt), .gnt_err_o(err));

  pixel_event_requester #(.Lvl_ROWS(R), .Lvl_COLS(C), .REFRACT_CYC(RC), .CNT_W(2)) dut_sat (
    .grp_release_clk(clk), .reset_i(rst), .enable_i(en), .event_i(ev), .gnt_i(gn),
    .grp_release_i(rel), .req_o(req_s), .grp_enable_o(genb_s), .pending_o(pend_s),
    .drop_cnt_o(dcnt_s), .gnt_err_o(err_s));

  // Behavioural model: which pixels hold a request, which wait for the next
  // group, how many blind cycles remain, plus group flag, drop total, error.
  bit m_armed[N], m_pend[N];
  int m_blind[N];
  bit m_grp, m_err;
  int m_drops;

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin m_armed[p] = 0; m_pend[p] = 0; m_blind[p] = 0; end
    m_grp = 0; m_err = 0; m_drops = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] e, g;
    int hot = 0;
    bit any = 0;
    e = ev; g = gn;
    for (int p = 0; p < N; p++) if (g[p]) begin hot++; if (!m_armed[p]) m_err = 1; end
    if (hot > 1) m_err = 1;
    for (int p = 0; p < N; p++) begin
      if (!en) begin
        m_armed[p] = 0; m_pend[p] = 0;
        if (m_blind[p] > 0) m_blind[p]--;
      end else if (m_armed[p]) begin
        if (e[p]) m_drops++;
        if (g[p]) begin m_armed[p] = 0; m_blind[p] = RC; end
      end else if (m_pend[p]) begin
        if (e[p]) m_drops++;
        if (rel) begin m_pend[p] = 0; m_armed[p] = 1; end
      end else if (m_blind[p] > 0) begin
        if (e[p]) m_drops++;
        m_blind[p]--;
      end else if (e[p]) begin
        if (!m_grp || rel) m_armed[p] = 1; else m_pend[p] = 1;
      end
    end
    for (int p = 0; p < N; p++) any |= m_armed[p];
    m_grp = !en ? 1'b0 : (rel ? any : (m_grp | any));
  endtask

  function automatic logic [N-1:0] exp_req();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = m_armed[p] & en;
    return r;
  endfunction
  function automatic logic exp_genb();
    bit any = 0;
    for (int p = 0; p < N; p++) any |= m_armed[p];
    return m_grp & !any;
  endfunction
  function automatic logic exp_pend();
    bit any = 0;
    for (int p = 0; p < N; p++) any |= m_pend[p];
    return any;
  endfunction

  // Advance one clock: model sees the same inputs the DUT samples, then the
  // one-cycle pulses are cleared just after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    ev = '0; gn = '0; rel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ev = '0; gn = '0; rel = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    #2;
    checks++; if (req !== 4'b0 || req_s !== 4'b0) begin errors++; $display("FAIL reset_req actual=%b/%b expected=0000", req, req_s); end
    checks++; if ({genb, pend, err, genb_s, pend_s, err_s} !== 6'b0) begin errors++; $display("FAIL reset_flags actual=%b expected=000000", {genb, pend, err, genb_s, pend_s, err_s}); end
    checks++; if (dcnt !== 8'd0 || dcnt_s !== 2'd0) begin errors++; $display("FAIL reset_cnt actual=%0d/%0d expected=0", dcnt, dcnt_s); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (req !== 4'b0 || genb !== 1'b0) begin errors++; $display("FAIL reset_hold actual=%b,%b expected=0000,0", req, genb); end
  endtask

  task automatic test_basic();
    do_reset(); en = 1'b1;
    ev = 4'b0010; cycle();                              // c1
    checks++; if (req !== 4'b0010) begin errors++; $display("FAIL basic_req actual=%b expected=0010", req); end
    cycle(); cycle();                                   // c3
    gn = 4'b0010; cycle();                              // c4
    checks++; if (req !== 4'b0000 || genb !== 1'b1) begin errors++; $display("FAIL basic_gnt actual=%b,%b expected=0000,1", req, genb); end
    cycle();                                            // c5
    ev = 4'b0010; cycle();                              // c6
    checks++; if (dcnt !== 8'd1) begin errors++; $display("FAIL basic_drop actual=%0d expected=1", dcnt); end
    cycle(); cycle();                                   // c8
    ev = 4'b0010; cycle();                              // c9
    checks++; if (pend !== 1'b1 || req !== 4'b0) begin errors++; $display("FAIL basic_pending actual=%b,%b expected=1,0000", pend, req); end
    checks++; if (dcnt !== 8'd1) begin errors++; $display("FAIL basic_nodrop actual=%0d expected=1", dcnt); end
  endtask

  task automatic test_freeze();
    do_reset(); en = 1'b1;
    ev = 4'b0001; cycle(); cycle();                     // c2
    ev = 4'b1000; cycle();                              // c3
    checks++; if (req !== 4'b0001 || pend !== 1'b1) begin errors++; $display("FAIL freeze_hold actual=%b,%b expected=0001,1", req, pend); end
    gn = 4'b0001; cycle();                              // c4
    checks++; if (req !== 4'b0 || genb !== 1'b1 || pend !== 1'b1) begin errors++; $display("FAIL freeze_drain actual=%b,%b,%b expected=0000,1,1", req, genb, pend); end
    cycle(); cycle();                                   // c6
    rel = 1'b1; cycle();                                // c7
    checks++; if (req !== 4'b1000 || pend !== 1'b0 || genb !== 1'b0) begin errors++; $display("FAIL freeze_release actual=%b,%b,%b expected=1000,0,0", req, pend, genb); end
  endtask

  task automatic test_release_join();
    do_reset(); en = 1'b1;
    ev = 4'b0001; cycle();
    ev = 4'b1000; cycle();
    gn = 4'b0001; cycle();
    checks++; if (genb !== 1'b1 || pend !== 1'b1) begin errors++; $display("FAIL join_pre actual=%b,%b expected=1,1", genb, pend); end
    rel = 1'b1; ev = 4'b0100; cycle();
    checks++; if (req !== 4'b1100 || pend !== 1'b0 || genb !== 1'b0) begin errors++; $display("FAIL join_arm actual=%b,%b,%b expected=1100,0,0", req, pend, genb); end
    gn = 4'b0100; cycle();
    checks++; if (req !== 4'b1000 || genb !== 1'b0) begin errors++; $display("FAIL join_partial actual=%b,%b expected=1000,0", req, genb); end
    gn = 4'b1000; cycle();
    checks++; if (req !== 4'b0 || genb !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL join_done actual=%b,%b,%b expected=0000,1,0", req, genb, err); end
  endtask

  task automatic test_gnt_err();
    do_reset(); en = 1'b1;
    gn = 4'b1000; cycle();
    checks++; if (err !== 1'b1 || req !== 4'b0 || pend !== 1'b0 || genb !== 1'b0) begin errors++; $display("FAIL err_idle actual=%b,%b,%b,%b expected=1,0000,0,0", err, req, pend, genb); end
    cycle(); cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky actual=%b expected=1", err); end
    ev = 4'b1000; cycle();
    checks++; if (req !== 4'b1000) begin errors++; $display("FAIL err_nochange actual=%b expected=1000", req); end
    do_reset();
    ev = 4'b0011; cycle();
    checks++; if (req !== 4'b0011 || err !== 1'b0) begin errors++; $display("FAIL multi_pre actual=%b,%b expected=0011,0", req, err); end
    gn = 4'b0011; cycle();
    checks++; if (req !== 4'b0 || err !== 1'b1 || genb !== 1'b1) begin errors++; $display("FAIL multi_gnt actual=%b,%b,%b expected=0000,1,1", req, err, genb); end
  endtask

  task automatic test_disable();
    do_reset(); en = 1'b1;
    ev = 4'b0011; cycle();                              // c1
    gn = 4'b0010; ev = 4'b0100; cycle();                // c2
    checks++; if (req !== 4'b0001 || pend !== 1'b1) begin errors++; $display("FAIL dis_pre actual=%b,%b expected=0001,1", req, pend); end
    en = 1'b0; ev = 4'b1000; #1;
    checks++; if (req !== 4'b0) begin errors++; $display("FAIL dis_mask actual=%b expected=0000", req); end
    cycle();                                            // c3
    checks++; if (pend !== 1'b0 || genb !== 1'b0 || dcnt !== 8'd0) begin errors++; $display("FAIL dis_clear actual=%b,%b,%0d expected=0,0,0", pend, genb, dcnt); end
    en = 1'b1; cycle();                                 // c4
    ev = 4'b0010; cycle();                              // c5
    checks++; if (dcnt !== 8'd1 || req !== 4'b0) begin errors++; $display("FAIL dis_refract actual=%0d,%b expected=1,0000", dcnt, req); end
    ev = 4'b0010; cycle();                              // c6
    checks++; if (req !== 4'b0010 || dcnt !== 8'd1) begin errors++; $display("FAIL dis_idle actual=%b,%0d expected=0010,1", req, dcnt); end
  endtask

  task automatic test_saturate();
    do_reset(); en = 1'b1;
    ev = 4'b0011; cycle();
    ev = 4'b0011; cycle();
    checks++; if (dcnt !== 8'd2 || dcnt_s !== 2'd2) begin errors++; $display("FAIL sat_multi actual=%0d/%0d expected=2/2", dcnt, dcnt_s); end
    ev = 4'b0011; cycle();
    ev = 4'b0001; gn = 4'b0100; cycle();
    checks++; if (dcnt !== 8'd5 || dcnt_s !== 2'd3) begin errors++; $display("FAIL sat_clamp actual=%0d/%0d expected=5/3", dcnt, dcnt_s); end
    checks++; if (err !== 1'b1 || req !== 4'b0011) begin errors++; $display("FAIL sat_state actual=%b,%b expected=1,0011", err, req); end
    rst = 1'b1; model_reset(); #1;
    checks++; if ({req, req_s, genb, pend, err, genb_s, pend_s, err_s} !== 14'b0 || dcnt !== 8'd0 || dcnt_s !== 2'd0) begin
      errors++; $display("FAIL async_reset actual=%b,%b,%b,%b,%b,%0d,%0d expected=all zero", req, req_s, genb, pend, err, dcnt, dcnt_s);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] pick;
    int cand[$];
    for (int it = 0; it < 600; it++) begin
      if (it % 150 == 0) do_reset();
      en = ($urandom_range(0, 19) != 0);
      ev = 4'($urandom) & 4'($urandom);
      gn = '0;
      cand.delete();
      for (int p = 0; p < N; p++) if (m_armed[p]) cand.push_back(p);
      if ($urandom_range(0, 39) == 0) gn = 4'($urandom);
      else if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = '0; pick[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1; gn = pick;
      end
      rel = (exp_genb() && $urandom_range(0, 1) == 1) || ($urandom_range(0, 29) == 0);
      #1;
      checks++; if (req !== exp_req() || req_s !== exp_req()) begin errors++; $display("FAIL rnd_req it=%0d actual=%b/%b expected=%b", it, req, req_s, exp_req()); end
      checks++; if (genb !== exp_genb() || genb_s !== exp_genb()) begin errors++; $display("FAIL rnd_genb it=%0d actual=%b/%b expected=%b", it, genb, genb_s, exp_genb()); end
      checks++; if (pend !== exp_pend() || pend_s !== exp_pend()) begin errors++; $display("FAIL rnd_pend it=%0d actual=%b/%b expected=%b", it, pend, pend_s, exp_pend()); end
      checks++; if (err !== m_err || err_s !== m_err) begin errors++; $display("FAIL rnd_err it=%0d actual=%b/%b expected=%b", it, err, err_s, m_err); end
      checks++; if (dcnt !== 8'((m_drops > 255) ? 255 : m_drops)) begin errors++; $display("FAIL rnd_cnt it=%0d actual=%0d expected=%0d", it, dcnt, (m_drops > 255) ? 255 : m_drops); end
      checks++; if (dcnt_s !== 2'((m_drops > 3) ? 3 : m_drops)) begin errors++; $display("FAIL rnd_cnt_sat it=%0d actual=%0d expected=%0d", it, dcnt_s, (m_drops > 3) ? 3 : m_drops); end
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_freeze();
    test_release_join();
    test_gnt_err();
    test_disable();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
